nn_weight_loader: RTL

- Sequences a host word stream into the weight/bias broadcast bus that every neuron in the network listens on: `weightValid`, `weightValue`, `biasValid`, `biasValue`, `config_layer_num` and `config_neuron_num`.
- Sits between the host/DMA staging stream and the neuron array.
- Parses per-neuron headers and drives each neuron's address tags.
- Emits one weight per accepted word, then the bias; a terminator header ends the load.

---
 rtl/nn_weight_loader_if.sv | 26 ++
 rtl/nn_weight_loader.sv | 132 +++++++++++++
 2 files changed

// File: rtl/nn_weight_loader_if.sv
// rtl/nn_weight_loader_if.sv - host stream and weight/bias broadcast bus bundle
interface nn_weight_loader_if;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        weightValid;
    logic [31:0] weightValue;
    logic        biasValid;
    logic [31:0] biasValue;
    logic [31:0] config_layer_num;
    logic [31:0] config_neuron_num;

    // Host side: drives the word stream, observes the broadcast bus.
    modport master (
        output s_data, s_valid,
        input  s_ready, weightValid, weightValue, biasValid, biasValue,
               config_layer_num, config_neuron_num
    );

    // Loader side: consumes the word stream, drives the broadcast bus.
    modport slave (
        input  s_data, s_valid,
        output s_ready, weightValid, weightValue, biasValid, biasValue,
               config_layer_num, config_neuron_num
    );
endinterface

// File: rtl/nn_weight_loader.sv
// rtl/nn_weight_loader.sv - header-parsing weight/bias loader; optional NN_WEIGHT_LOADER_CHECKSUM_EN
module nn_weight_loader #(
    parameter int maxNumWeight  = 784,
    parameter int layerIdWidth  = 8,
    parameter int neuronIdWidth = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    nn_weight_loader_if.slave  bus,
    output logic               busy,
    output logic               done,
    output logic               error
);
    localparam int          CNT_W = $clog2(maxNumWeight + 1);
    localparam logic [31:0] MAX_N = 32'(maxNumWeight);

    typedef enum logic [2:0] {IDLE, HDR, WGT, BIAS, TERM, DONE} state_t;

    state_t                   state, state_next;
    logic [CNT_W-1:0]         wcnt;
    logic                     accept;
    logic [layerIdWidth-1:0]  hdr_layer;
    logic [neuronIdWidth-1:0] hdr_neuron;
    logic [15:0]              hdr_count;
    logic                     is_term;
    logic                     oversize;
    logic                     start_ok;
`ifdef NN_WEIGHT_LOADER_CHECKSUM_EN
    logic [31:0]              csum;
`endif

    assign hdr_layer  = bus.s_data[31 -: layerIdWidth];
    assign hdr_neuron = bus.s_data[23 -: neuronIdWidth];
    assign hdr_count  = bus.s_data[15:0];
    assign is_term    = &hdr_layer;
    assign oversize   = {16'd0, hdr_count} > MAX_N;
    assign start_ok   = start && (state == IDLE || state == DONE);
    assign busy       = (state == HDR) || (state == WGT) || (state == BIAS) || (state == TERM);
`ifdef NN_WEIGHT_LOADER_CHECKSUM_EN
    assign bus.s_ready = (state == HDR) || (state == WGT) || (state == BIAS) || (state == TERM);
`else
    assign bus.s_ready = (state == HDR) || (state == WGT) || (state == BIAS);
`endif
    assign accept     = bus.s_valid && bus.s_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state decode: headers steer to weights, bias or termination.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: if (start) state_next = HDR;
            HDR: if (accept) begin
                if (is_term)                state_next = TERM;
                else if (oversize)          state_next = DONE;
                else if (hdr_count == 16'd0) state_next = BIAS;
                else                        state_next = WGT;
            end
            WGT:  if (accept && wcnt == CNT_W'(1)) state_next = BIAS;
            BIAS: if (accept) state_next = HDR;
`ifdef NN_WEIGHT_LOADER_CHECKSUM_EN
            TERM: if (accept) state_next = DONE;
`else
            TERM: state_next = DONE;
`endif
            default: state_next = IDLE;
        endcase
    end

    // Datapath: address tags, weight/bias words, pulses, counter and status.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.weightValid       <= 1'b0;
            bus.weightValue       <= 32'd0;
            bus.biasValid         <= 1'b0;
            bus.biasValue         <= 32'd0;
            bus.config_layer_num  <= 32'd0;
            bus.config_neuron_num <= 32'd0;
            wcnt                  <= '0;
            done                  <= 1'b0;
            error                 <= 1'b0;
        end else begin
            bus.weightValid <= 1'b0;
            bus.biasValid   <= 1'b0;
            done            <= 1'b0;
            if (start_ok) error <= 1'b0;
            case (state)
                HDR: if (accept && !is_term) begin
                    bus.config_layer_num  <= 32'(hdr_layer);
                    bus.config_neuron_num <= 32'(hdr_neuron);
                    if (oversize) begin
                        error <= 1'b1;
                        done  <= 1'b1;
                    end else begin
                        wcnt <= hdr_count[CNT_W-1:0];
                    end
                end
                WGT: if (accept) begin
                    bus.weightValue <= bus.s_data;
                    bus.weightValid <= 1'b1;
                    wcnt            <= wcnt - CNT_W'(1);
                end
                BIAS: if (accept) begin
                    bus.biasValue <= bus.s_data;
                    bus.biasValid <= 1'b1;
                end
`ifdef NN_WEIGHT_LOADER_CHECKSUM_EN
                TERM: if (accept) begin
                    done <= 1'b1;
                    if (bus.s_data != csum) error <= 1'b1;
                end
`else
                TERM: done <= 1'b1;
`endif
                default: ;
            endcase
        end
    end

`ifdef NN_WEIGHT_LOADER_CHECKSUM_EN
    // Running XOR over every accepted word ahead of the checksum word itself.
    always_ff @(posedge clk) begin
        if (rst || start_ok)               csum <= 32'd0;
        else if (accept && state != TERM)  csum <= csum ^ bus.s_data;
    end
`endif
endmodule
